// File: rtl/perf_xbar_n.sv
// rtl/perf_xbar_n.sv - N-channel peripheral crossbar with write counters, drop counter and enable mask
module perf_xbar_n #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int SEL_LSB    = 8,
    parameter int SEL_WIDTH  = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        cpu_din,
    input  logic [ADDR_WIDTH-1:0]        cpu_ain,
    input  logic                         cpu_wren,
    output logic [DATA_WIDTH-1:0]        cpu_dout,
    output logic [NUM_CH*DATA_WIDTH-1:0] dout_flat,
    output logic [NUM_CH*ADDR_WIDTH-1:0] aout_flat,
    output logic [NUM_CH-1:0]            wrout,
    input  logic [NUM_CH*DATA_WIDTH-1:0] din_flat
);

    // Select values at or above NUM_CH address the internal bank.
    localparam logic [SEL_WIDTH-1:0] CH_LIMIT = SEL_WIDTH'(NUM_CH);
    localparam logic [SEL_LSB-1:0]   IDX_DROP = SEL_LSB'(NUM_CH);
    localparam logic [SEL_LSB-1:0]   IDX_MASK = SEL_LSB'(NUM_CH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [SEL_WIDTH-1:0]  sel;
    logic [SEL_LSB-1:0]    idx;
    logic                  is_bank;

    logic [NUM_CH-1:0]     ch_hit;
    logic [NUM_CH-1:0]     acc_wr;
    logic                  drop_wr;
    logic                  bank_mask_wr;
    logic                  bank_clr;

    logic [ADDR_WIDTH-1:0] aout_r [NUM_CH];
    logic [DATA_WIDTH-1:0] dout_r [NUM_CH];

    logic [CNT_WIDTH-1:0]  wcnt [NUM_CH];
    logic [CNT_WIDTH-1:0]  drop_cnt;
    logic [NUM_CH-1:0]     mask;

    logic                  rd_bank;
    logic [SEL_WIDTH-1:0]  rd_sel;
    logic [SEL_LSB-1:0]    rd_idx;
    logic [DATA_WIDTH-1:0] bank_val;
    logic [DATA_WIDTH-1:0] ch_val;

    assign sel     = cpu_ain[SEL_LSB +: SEL_WIDTH];
    assign idx     = cpu_ain[SEL_LSB-1:0];
    assign is_bank = (sel >= CH_LIMIT);

    // Decode the current CPU cycle into channel hits, accepted/dropped writes and bank writes.
    always_comb begin
        ch_hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_hit[k] = !is_bank && (sel == SEL_WIDTH'(k));
        end
        acc_wr       = ch_hit & mask & {NUM_CH{cpu_wren}};
        drop_wr      = cpu_wren && (|(ch_hit & ~mask));
        bank_mask_wr = cpu_wren && is_bank && (idx == IDX_MASK);
        bank_clr     = cpu_wren && is_bank && (idx != IDX_MASK);
    end

    // Channel ports: the selected channel captures address/data every cycle; strobes gated by mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                aout_r[k] <= '0;
                dout_r[k] <= '0;
            end
            wrout <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_hit[k]) begin
                    aout_r[k] <= cpu_ain;
                    dout_r[k] <= cpu_din;
                end
            end
            wrout <= acc_wr;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_flat
        assign aout_flat[k*ADDR_WIDTH +: ADDR_WIDTH] = aout_r[k];
        assign dout_flat[k*DATA_WIDTH +: DATA_WIDTH] = dout_r[k];
    end

    // Control/status bank: saturating counters, clear-on-write, and the channel enable mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                wcnt[k] <= '0;
            end
            drop_cnt <= '0;
            mask     <= '1;
        end else begin
            if (bank_mask_wr) begin
                mask <= cpu_din[NUM_CH-1:0];
            end
            if (bank_clr) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    wcnt[k] <= '0;
                end
                drop_cnt <= '0;
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (acc_wr[k] && (wcnt[k] != CNT_MAX)) begin
                        wcnt[k] <= wcnt[k] + CNT_WIDTH'(1);
                    end
                end
                if (drop_wr && (drop_cnt != CNT_MAX)) begin
                    drop_cnt <= drop_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Read pipeline stage 1: remember where this cycle's address points.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank <= 1'b0;
            rd_sel  <= '0;
            rd_idx  <= '0;
        end else begin
            rd_bank <= is_bank;
            rd_sel  <= sel;
            rd_idx  <= idx;
        end
    end

    // Bank register map lookup for the registered idx; unmapped indices read as zero.
    always_comb begin
        bank_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_idx == SEL_LSB'(k)) begin
                bank_val = DATA_WIDTH'(wcnt[k]);
            end
        end
        if (rd_idx == IDX_DROP) begin
            bank_val = DATA_WIDTH'(drop_cnt);
        end
        if (rd_idx == IDX_MASK) begin
            bank_val = DATA_WIDTH'(mask);
        end
    end

    // Channel read data mux for the registered select.
    always_comb begin
        ch_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_sel == SEL_WIDTH'(k)) begin
                ch_val = din_flat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read pipeline stage 2: register the returned value toward the CPU.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_dout <= '0;
        end else begin
            cpu_dout <= rd_bank ? bank_val : ch_val;
        end
    end

endmodule

// File: tb/tb_perf_xbar_n.sv
// tb/tb_perf_xbar_n.sv - scoreboard bench for perf_xbar_n with directed vectors
module tb_perf_xbar_n;

    localparam int NCH = 4;
    localparam int DW  = 64;
    localparam int AW  = 64;

    localparam int K_DOUT = 0;
    localparam int K_WR   = 1;
    localparam int K_AOUT = 2;
    localparam int K_CHD  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     cpu_din = '0;
    logic [AW-1:0]     cpu_ain = '0;
    logic              cpu_wren = 1'b0;
    logic [DW-1:0]     cpu_dout;
    logic [NCH*DW-1:0] dout_flat;
    logic [NCH*AW-1:0] aout_flat;
    logic [NCH-1:0]    wrout;
    logic [NCH*DW-1:0] din_flat = '0;

    typedef struct {
        string       name;
        int          kind;
        int          ch;
        logic [63:0] val;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    perf_xbar_n #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .SEL_LSB(8), .SEL_WIDTH(3), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .cpu_din(cpu_din), .cpu_ain(cpu_ain),
        .cpu_wren(cpu_wren), .cpu_dout(cpu_dout), .dout_flat(dout_flat),
        .aout_flat(aout_flat), .wrout(wrout), .din_flat(din_flat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mk(input int s, input int i);
        return (64'(s) << 8) | 64'(i);
    endfunction

    function automatic void exp_at(input string n, input int k, input int ch,
                                   input logic [63:0] v, input int off);
        exp_t e;
        e.name = n; e.kind = k; e.ch = ch; e.val = v; e.due = cyc + off;
        q.push_back(e);
    endfunction

    task automatic drive(input int s, input int i, input logic [63:0] d,
                         input logic w, input logic r);
        @(negedge clk);
        rst      = r;
        cpu_ain  = mk(s, i);
        cpu_din  = d;
        cpu_wren = w;
    endtask

    // Monitor: compare every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        logic [63:0] act;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due == cyc) begin
                case (q[i].kind)
                    K_DOUT:  act = cpu_dout;
                    K_WR:    act = 64'(wrout);
                    K_AOUT:  act = aout_flat[q[i].ch*AW +: AW];
                    default: act = dout_flat[q[i].ch*DW +: DW];
                endcase
                n_cmp++;
                if (act !== q[i].val) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got %h expected %h", q[i].name, cyc, act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        int guard;
        repeat (3) @(posedge clk);

        // Reset state and idle
        drive(0, 0, 0, 0, 0);
        exp_at("rst_dout", K_DOUT, 0, 0, 1);
        exp_at("rst_wrout", K_WR, 0, 0, 1);
        exp_at("rst_aout2", K_AOUT, 2, 0, 1);
        exp_at("rst_dout2", K_CHD, 2, 0, 1);

        // Mask read with two-cycle latency
        drive(4, 5, 0, 0, 0);
        exp_at("mask_lat1", K_DOUT, 0, 0, 1);
        exp_at("mask_rd", K_DOUT, 0, 64'hF, 2);

        // Write to channel 2
        drive(2, 'h10, 64'hAA, 1, 0);
        exp_at("wr2_strobe", K_WR, 0, 64'h4, 1);
        exp_at("wr2_aout", K_AOUT, 2, 64'h210, 1);
        exp_at("wr2_dout", K_CHD, 2, 64'hAA, 1);
        exp_at("wr2_aout1", K_AOUT, 1, 0, 1);
        exp_at("wr2_dout3", K_CHD, 3, 0, 1);
        drive(4, 2, 0, 0, 0);
        exp_at("wr2_pulse_end", K_WR, 0, 0, 1);
        exp_at("bank_hold_aout2", K_AOUT, 2, 64'h210, 1);
        exp_at("wcnt2", K_DOUT, 0, 1, 2);

        // Pipelined channel reads
        din_flat[1*DW +: DW] = 64'h1234;
        din_flat[3*DW +: DW] = 64'h3333;
        drive(1, 0, 0, 0, 0);
        exp_at("rd1_aout", K_AOUT, 1, 64'h100, 1);
        exp_at("rd1", K_DOUT, 0, 64'h1234, 2);
        drive(3, 0, 0, 0, 0);
        exp_at("rd3", K_DOUT, 0, 64'h3333, 2);
        drive(0, 0, 0, 0, 0);
        exp_at("rd0", K_DOUT, 0, 0, 2);

        // Mask 0b1101, blocked writes to channel 1
        drive(4, 5, 64'hD, 1, 0);
        exp_at("maskwr_strobe", K_WR, 0, 0, 1);
        exp_at("maskwr_rd", K_DOUT, 0, 64'hD, 2);
        drive(1, 0, 64'h55, 1, 0);
        exp_at("drop1_strobe", K_WR, 0, 0, 1);
        exp_at("drop1_rd", K_DOUT, 0, 64'h1234, 2);
        drive(1, 4, 64'h66, 1, 0);
        exp_at("drop2_strobe", K_WR, 0, 0, 1);
        exp_at("drop2_aout1", K_AOUT, 1, 64'h104, 1);
        exp_at("drop2_dout1", K_CHD, 1, 64'h66, 1);
        drive(4, 4, 0, 0, 0);
        exp_at("drop_cnt", K_DOUT, 0, 2, 2);
        drive(4, 1, 0, 0, 0);
        exp_at("wcnt1", K_DOUT, 0, 0, 2);
        drive(0, 0, 64'h77, 1, 0);
        exp_at("wr0_strobe", K_WR, 0, 64'h1, 1);
        drive(4, 0, 0, 0, 0);
        exp_at("wr0_pulse_end", K_WR, 0, 0, 1);
        exp_at("wcnt0", K_DOUT, 0, 1, 2);

        // Saturation with back-to-back strobes
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 64'(i), 1, 0);
            exp_at("b2b_strobe", K_WR, 0, 64'h1, 1);
        end
        drive(4, 0, 0, 0, 0);
        exp_at("sat_pulse_end", K_WR, 0, 0, 1);
        exp_at("wcnt0_sat", K_DOUT, 0, 64'hF, 2);
        drive(4, 4, 0, 0, 0);
        exp_at("drop_keep", K_DOUT, 0, 2, 2);

        // Bank clear
        drive(4, 0, 0, 1, 0);
        exp_at("clr_strobe", K_WR, 0, 0, 1);
        drive(4, 0, 0, 0, 0);
        exp_at("clr_wcnt0", K_DOUT, 0, 0, 2);
        drive(4, 4, 0, 0, 0);
        exp_at("clr_drop", K_DOUT, 0, 0, 2);
        drive(4, 5, 0, 0, 0);
        exp_at("clr_mask_kept", K_DOUT, 0, 64'hD, 2);

        // Reset during a channel 3 write with a read in flight
        drive(1, 0, 0, 0, 0);
        drive(3, 0, 64'h99, 1, 1);
        exp_at("rstwr_strobe", K_WR, 0, 0, 1);
        exp_at("rstwr_dout", K_DOUT, 0, 0, 1);
        exp_at("rstwr_aout3", K_AOUT, 3, 0, 1);
        exp_at("rstwr_dout3", K_CHD, 3, 0, 1);
        drive(4, 3, 0, 0, 0);
        exp_at("post_rst_strobe", K_WR, 0, 0, 1);
        exp_at("post_rst_dout", K_DOUT, 0, 0, 1);
        exp_at("post_rst_wcnt3", K_DOUT, 0, 0, 2);
        drive(4, 5, 0, 0, 0);
        exp_at("post_rst_mask", K_DOUT, 0, 64'hF, 2);
        drive(3, 0, 64'h5, 1, 0);
        exp_at("wr3_strobe", K_WR, 0, 64'h8, 1);
        drive(4, 3, 0, 0, 0);
        exp_at("wcnt3", K_DOUT, 0, 1, 2);
        drive(0, 0, 0, 0, 0);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        foreach (q[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never compared, due cyc %0d, now %0d", q[i].name, q[i].due, cyc);
        end

        @(negedge clk);
        n_cmp++;
        if (aout_flat[3*AW +: AW] !== 64'h300) begin
            n_bad++;
            $display("FAIL final_aout3: got %h", aout_flat[3*AW +: AW]);
        end
        n_cmp++;
        if (dout_flat[3*DW +: DW] !== 64'h5) begin
            n_bad++;
            $display("FAIL final_dout3: got %h", dout_flat[3*DW +: DW]);
        end
        n_cmp++;
        if (wrout !== 4'b0000) begin
            n_bad++;
            $display("FAIL final_wrout: got %b", wrout);
        end
        n_cmp++;
        if (cpu_dout !== 64'h0) begin
            n_bad++;
            $display("FAIL final_cpu_dout: got %h", cpu_dout);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
